// File: rtl/pcie_us_axil_rq_wr.sv
// pcie_us_axil_rq_wr
// AXI-Lite slave that turns each single-DW write into one posted Memory Write
// TLP on the UltraScale PCIe requester-request (RQ) AXI-stream. The block holds
// one AW and one W register. Once both are full it emits the TLP, then answers
// on B. If bus mastering is disabled, the write is dropped and answered with
// SLVERR.
module pcie_us_axil_rq_wr #(
    parameter int AXIS_PCIE_DATA_WIDTH    = 256,
    parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int AXIS_PCIE_RQ_USER_WIDTH = 60,
    parameter int AXIL_ADDR_WIDTH         = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,

    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_rq_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_rq_tkeep,
    output logic                               m_axis_rq_tvalid,
    input  logic                               m_axis_rq_tready,
    output logic                               m_axis_rq_tlast,
    output logic [AXIS_PCIE_RQ_USER_WIDTH-1:0] m_axis_rq_tuser,

    input  logic [AXIL_ADDR_WIDTH-1:0]         s_axil_awaddr,
    input  logic [2:0]                         s_axil_awprot,
    input  logic                               s_axil_awvalid,
    output logic                               s_axil_awready,
    input  logic [31:0]                        s_axil_wdata,
    input  logic [3:0]                         s_axil_wstrb,
    input  logic                               s_axil_wvalid,
    output logic                               s_axil_wready,
    output logic [1:0]                         s_axil_bresp,
    output logic                               s_axil_bvalid,
    input  logic                               s_axil_bready,

    input  logic                               bus_master_enable,
    output logic                               status_error
);

    localparam int DW = AXIS_PCIE_DATA_WIDTH;
    localparam int KW = AXIS_PCIE_KEEP_WIDTH;
    localparam int UW = AXIS_PCIE_RQ_USER_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TX   = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_reg;
    logic [1:0]    beat_cnt_reg;
    logic          aw_full_reg;
    logic          w_full_reg;
    logic [63:2]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    wstrb_reg;
    logic          awready_reg;
    logic          wready_reg;
    logic          bvalid_reg;
    logic [1:0]    bresp_reg;
    logic          status_error_reg;
    logic          tvalid_reg;
    logic          tlast_reg;
    logic [KW-1:0] tkeep_reg;
    logic [DW-1:0] tdata_reg;
    logic [UW-1:0] tuser_reg;

    logic          aw_hs;
    logic          w_hs;
    logic          beat_acc;
    logic [127:0]  desc;
    logic [1:0]    beat_sel;
    logic [DW-1:0] beat_data;
    logic [KW-1:0] beat_keep;
    logic          beat_last;
    logic          unused_ok;

    assign aw_hs    = s_axil_awvalid && awready_reg;
    assign w_hs     = s_axil_wvalid && wready_reg;
    assign beat_acc = tvalid_reg && m_axis_rq_tready;

    // Descriptor: DW0-1 dword-aligned address. DW2 holds dword count 1 and
    // request type MemWr (0001). DW3 (tag, completer ID, attributes) is zero.
    assign desc = {32'h0000_0000, 16'h0000, 1'b0, 4'b0001, 11'd1,
                   addr_reg[63:32], addr_reg[31:2], 2'b00};

    // Beat index to load next: beat 0 on the IDLE->TX entry, otherwise the one
    // after the beat currently being accepted.
    assign beat_sel = (state_reg == ST_TX) ? beat_cnt_reg + 2'd1 : 2'd0;

    assign unused_ok = ^{s_axil_awprot, s_axil_awaddr[1:0], beat_sel};

    generate
        if (DW == 256) begin : g_w256
            // Whole TLP in one beat: descriptor in DW0-3, payload in DW4.
            always_comb begin
                beat_data          = '0;
                beat_data[127:0]   = desc;
                beat_data[159:128] = wdata_reg;
                beat_keep          = 8'h1F;
                beat_last          = 1'b1;
            end
        end else if (DW == 128) begin : g_w128
            // Descriptor beat, then a payload beat.
            always_comb begin
                beat_data = '0;
                beat_keep = 4'h1;
                beat_last = 1'b1;
                if (beat_sel == 2'd0) begin
                    beat_data = desc;
                    beat_keep = 4'hF;
                    beat_last = 1'b0;
                end else begin
                    beat_data[31:0] = wdata_reg;
                end
            end
        end else begin : g_w64
            // Two descriptor beats (DW0-1, DW2-3), then a payload beat.
            always_comb begin
                beat_data = '0;
                beat_keep = 2'b01;
                beat_last = 1'b1;
                case (beat_sel)
                    2'd0: begin
                        beat_data = desc[63:0];
                        beat_keep = 2'b11;
                        beat_last = 1'b0;
                    end
                    2'd1: begin
                        beat_data = desc[127:64];
                        beat_keep = 2'b11;
                        beat_last = 1'b0;
                    end
                    default: beat_data[31:0] = wdata_reg;
                endcase
            end
        end
    endgenerate

    // Capture the AXI-Lite channels, then sequence IDLE -> TX/RESP -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            beat_cnt_reg     <= 2'd0;
            aw_full_reg      <= 1'b0;
            w_full_reg       <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            wstrb_reg        <= '0;
            awready_reg      <= 1'b0;
            wready_reg       <= 1'b0;
            bvalid_reg       <= 1'b0;
            bresp_reg        <= 2'b00;
            status_error_reg <= 1'b0;
            tvalid_reg       <= 1'b0;
            tlast_reg        <= 1'b0;
            tkeep_reg        <= '0;
            tdata_reg        <= '0;
            tuser_reg        <= '0;
        end else begin
            status_error_reg <= 1'b0;
            // Ready drops on the accepting edge. It comes back only one
            // cycle after the full flag clears.
            awready_reg      <= !aw_full_reg && !aw_hs;
            wready_reg       <= !w_full_reg && !w_hs;

            if (aw_hs) begin
                addr_reg    <= s_axil_awaddr[63:2];
                aw_full_reg <= 1'b1;
            end
            if (w_hs) begin
                wdata_reg  <= s_axil_wdata;
                wstrb_reg  <= s_axil_wstrb;
                w_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (aw_full_reg && w_full_reg) begin
                        if (bus_master_enable) begin
                            state_reg    <= ST_TX;
                            beat_cnt_reg <= 2'd0;
                            tvalid_reg   <= 1'b1;
                            tdata_reg    <= beat_data;
                            tkeep_reg    <= beat_keep;
                            tlast_reg    <= beat_last;
                            tuser_reg    <= {{(UW-8){1'b0}}, 4'b0000, wstrb_reg};
                        end else begin
                            state_reg        <= ST_RESP;
                            bresp_reg        <= 2'b10;
                            status_error_reg <= 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    if (beat_acc) begin
                        if (tlast_reg) begin
                            state_reg  <= ST_RESP;
                            bresp_reg  <= 2'b00;
                            tvalid_reg <= 1'b0;
                            tlast_reg  <= 1'b0;
                            tdata_reg  <= '0;
                            tkeep_reg  <= '0;
                            tuser_reg  <= '0;
                        end else begin
                            beat_cnt_reg <= beat_sel;
                            tdata_reg    <= beat_data;
                            tkeep_reg    <= beat_keep;
                            tlast_reg    <= beat_last;
                        end
                    end
                end
                ST_RESP: begin
                    if (!bvalid_reg) begin
                        bvalid_reg <= 1'b1;
                    end else if (s_axil_bready) begin
                        bvalid_reg  <= 1'b0;
                        aw_full_reg <= 1'b0;
                        w_full_reg  <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_rq_tdata  = tdata_reg;
    assign m_axis_rq_tkeep  = tkeep_reg;
    assign m_axis_rq_tvalid = tvalid_reg;
    assign m_axis_rq_tlast  = tlast_reg;
    assign m_axis_rq_tuser  = tuser_reg;
    assign s_axil_awready   = awready_reg;
    assign s_axil_wready    = wready_reg;
    assign s_axil_bvalid    = bvalid_reg;
    assign s_axil_bresp     = bresp_reg;
    assign status_error     = status_error_reg;

endmodule

// File: tb/tb_pcie_us_axil_rq_wr.sv
// Bench for pcie_us_axil_rq_wr: three instances at widths 256 (idx 0),
// 128 (idx 1) and 64 (idx 2) driven with directed writes.
module tb_pcie_us_axil_rq_wr;

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         last;
        logic [59:0]  user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot;
    logic [2:0]  awvalid, wvalid, bready, tready_set, tready;
    logic        rand_en, rnd_bit, bme;

    logic [2:0]   awready, wready, bvalid, status_error, tvalid, tlast;
    logic [1:0]   bresp_0, bresp_1, bresp_2;
    logic [255:0] tdata_0;
    logic [127:0] tdata_1;
    logic [63:0]  tdata_2;
    logic [7:0]   tkeep_0;
    logic [3:0]   tkeep_1;
    logic [1:0]   tkeep_2;
    logic [59:0]  tuser_0, tuser_1, tuser_2;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    se0 = 0, se1 = 0, se2 = 0;
    beat_t q0[$], q1[$], q2[$];

    assign tready = {tready_set[2], rand_en ? rnd_bit : tready_set[1], tready_set[0]};

    pcie_us_axil_rq_wr #(.AXIS_PCIE_DATA_WIDTH(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n),
        .m_axis_rq_tdata(tdata_0), .m_axis_rq_tkeep(tkeep_0), .m_axis_rq_tvalid(tvalid[0]),
        .m_axis_rq_tready(tready[0]), .m_axis_rq_tlast(tlast[0]), .m_axis_rq_tuser(tuser_0),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid[0]),
        .s_axil_awready(awready[0]), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid[0]), .s_axil_wready(wready[0]), .s_axil_bresp(bresp_0),
        .s_axil_bvalid(bvalid[0]), .s_axil_bready(bready[0]),
        .bus_master_enable(bme), .status_error(status_error[0])
    );

    pcie_us_axil_rq_wr #(.AXIS_PCIE_DATA_WIDTH(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n),
        .m_axis_rq_tdata(tdata_1), .m_axis_rq_tkeep(tkeep_1), .m_axis_rq_tvalid(tvalid[1]),
        .m_axis_rq_tready(tready[1]), .m_axis_rq_tlast(tlast[1]), .m_axis_rq_tuser(tuser_1),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid[1]),
        .s_axil_awready(awready[1]), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid[1]), .s_axil_wready(wready[1]), .s_axil_bresp(bresp_1),
        .s_axil_bvalid(bvalid[1]), .s_axil_bready(bready[1]),
        .bus_master_enable(bme), .status_error(status_error[1])
    );

    pcie_us_axil_rq_wr #(.AXIS_PCIE_DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .m_axis_rq_tdata(tdata_2), .m_axis_rq_tkeep(tkeep_2), .m_axis_rq_tvalid(tvalid[2]),
        .m_axis_rq_tready(tready[2]), .m_axis_rq_tlast(tlast[2]), .m_axis_rq_tuser(tuser_2),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid[2]),
        .s_axil_awready(awready[2]), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid[2]), .s_axil_wready(wready[2]), .s_axil_bresp(bresp_2),
        .s_axil_bvalid(bvalid[2]), .s_axil_bready(bready[2]),
        .bus_master_enable(bme), .status_error(status_error[2])
    );

    // Count one comparison; report it if observed differs from expected.
    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [255:0] d, input logic [7:0] k,
                                      input logic l, input logic [59:0] u);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.user = u;
        return b;
    endfunction

    function automatic logic [1:0] get_bresp(input int i);
        case (i)
            0:       return bresp_0;
            1:       return bresp_1;
            default: return bresp_2;
        endcase
    endfunction

    // Record accepted beats. Inputs change just after posedge, so the negedge
    // value of valid&&ready is what the next posedge sees.
    always @(negedge clk) begin
        if (tvalid[0] && tready[0]) q0.push_back(mk_beat(tdata_0, tkeep_0, tlast[0], tuser_0));
        if (tvalid[1] && tready[1]) q1.push_back(mk_beat(256'(tdata_1), 8'(tkeep_1), tlast[1], tuser_1));
        if (tvalid[2] && tready[2]) q2.push_back(mk_beat(256'(tdata_2), 8'(tkeep_2), tlast[2], tuser_2));
        if (status_error[0]) se0 <= se0 + 1;
        if (status_error[1]) se1 <= se1 + 1;
        if (status_error[2]) se2 <= se2 + 1;
    end

    // Stream stability on the 128-bit instance while it is back-pressured.
    logic         stall_prev = 1'b0;
    logic [192:0] held = '0;
    always @(negedge clk) begin
        if (stall_prev && rst_n) begin
            check_eq("stall_valid", 256'(tvalid[1]), 256'(1'b1));
            check_eq("stall_payload", 256'({tdata_1, tkeep_1, tlast[1], tuser_1}), 256'(held));
        end
        stall_prev <= tvalid[1] && !tready[1] && rst_n;
        held       <= {tdata_1, tkeep_1, tlast[1], tuser_1};
    end

    // Random back-pressure source for the 128-bit instance.
    always begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Pop one recorded beat of instance idx and compare every field.
    task automatic exp_beat(input int idx, input string tag, input logic [255:0] d,
                            input logic [7:0] k, input logic l, input logic [59:0] u);
        beat_t b;
        int    sz;
        sz = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
        check_eq({tag, "_present"}, 256'(sz > 0), 256'(1'b1));
        if (sz > 0) begin
            case (idx)
                0:       b = q0.pop_front();
                1:       b = q1.pop_front();
                default: b = q2.pop_front();
            endcase
            check_eq({tag, "_data"}, b.data, d);
            check_eq({tag, "_keep"}, 256'(b.keep), 256'(k));
            check_eq({tag, "_last"}, 256'(b.last), 256'(l));
            check_eq({tag, "_user"}, 256'(b.user), 256'(u));
        end
    endtask

    // One AXI-Lite write on instance idx. W leads AW by w_lead cycles. Bready
    // is held off bdelay cycles after bvalid.
    task automatic do_write(input int idx, input logic [63:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int w_lead, input int bdelay,
                            input logic exp_tx, output logic [1:0] resp);
        int   cyc;
        logic aw_done, w_done, aw_fire, w_fire, bseen;
        @(posedge clk);
        #1;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        wvalid[idx] = 1'b1;
        if (w_lead == 0) awvalid[idx] = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge clk);
            aw_fire = awvalid[idx] && awready[idx];
            w_fire  = wvalid[idx] && wready[idx];
            @(posedge clk);
            #1;
            cyc++;
            if (aw_fire) begin awvalid[idx] = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin wvalid[idx]  = 1'b0; w_done  = 1'b1; end
            if (!aw_done && cyc >= w_lead) awvalid[idx] = 1'b1;
        end
        awvalid[idx] = 1'b0;
        wvalid[idx]  = 1'b0;
        check_eq("aw_w_accepted", 256'({aw_done, w_done}), 256'(2'b11));
        @(negedge clk);
        check_eq("tvalid_lat_n", 256'(tvalid[idx]), 256'(1'b0));
        @(negedge clk);
        check_eq("tvalid_lat_n1", 256'(tvalid[idx]), 256'(exp_tx));
        cyc   = 0;
        bseen = 1'b0;
        while (!bseen && cyc < 400) begin
            if (bvalid[idx]) bseen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("bvalid_seen", 256'(bseen), 256'(1'b1));
        resp = get_bresp(idx);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check_eq("b_hold_valid", 256'(bvalid[idx]), 256'(1'b1));
            check_eq("b_hold_ready", 256'({awready[idx], wready[idx]}), 256'(2'b00));
        end
        bready[idx] = 1'b1;
        @(posedge clk);
        #1;
        bready[idx] = 1'b0;
        @(negedge clk);
        check_eq("b_done_valid", 256'(bvalid[idx]), 256'(1'b0));
        check_eq("rdy_after_b_k", 256'({awready[idx], wready[idx]}), 256'(2'b00));
        @(negedge clk);
        check_eq("rdy_after_b_k1", 256'({awready[idx], wready[idx]}), 256'(2'b11));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [63:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          n, s_before, b_count, cyc;

        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; awprot = '0;
        awvalid = '0; wvalid = '0; bready = '0; tready_set = '0;
        rand_en = 1'b0; rnd_bit = 1'b0; bme = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_valid_last", 256'({tvalid, tlast}), 256'(0));
        check_eq("rst_tdata", tdata_0 | 256'(tdata_1) | 256'(tdata_2), 256'(0));
        check_eq("rst_keep", 256'({tkeep_0, tkeep_1, tkeep_2}), 256'(0));
        check_eq("rst_user", 256'({tuser_0, tuser_1, tuser_2}), 256'(0));
        check_eq("rst_axil", 256'({awready, wready, bvalid, status_error, bresp_0, bresp_1, bresp_2}), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rdy_before_edge", 256'({awready, wready}), 256'(0));
        @(negedge clk);
        check_eq("rdy_after_edge", 256'({awready, wready}), 256'(6'h3F));

        // Width 256: AW and W together.
        tready_set = 3'b111;
        do_write(0, 64'h0000_0001_2345_6788, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1, resp);
        check_eq("w256_bresp", 256'(resp), 256'(2'b00));
        check_eq("w256_nbeats", 256'(q0.size()), 256'(1));
        exp_beat(0, "w256", {96'h0, 32'hDEAD_BEEF, 32'h0, 32'h0000_0801, 32'h0000_0001, 32'h2345_6788},
                 8'h1F, 1'b1, 60'h0F);

        // Width 64: W three cycles ahead of AW, unaligned address.
        do_write(2, 64'h0000_0000_8000_1003, 32'hCAFE_F00D, 4'b0110, 3, 0, 1'b1, resp);
        check_eq("w64_bresp", 256'(resp), 256'(2'b00));
        check_eq("w64_nbeats", 256'(q2.size()), 256'(3));
        exp_beat(2, "w64_b0", 256'(64'h0000_0000_8000_1000), 8'h03, 1'b0, 60'h6);
        exp_beat(2, "w64_b1", 256'(64'h0000_0000_0000_0801), 8'h03, 1'b0, 60'h6);
        exp_beat(2, "w64_b2", 256'(64'h0000_0000_CAFE_F00D), 8'h01, 1'b1, 60'h6);

        // Bus mastering disabled: dropped with SLVERR and a single error pulse.
        bme = 1'b0;
        s_before = se0;
        n = q0.size();
        do_write(0, 64'h0000_0000_0000_1000, 32'h1111_2222, 4'hF, 0, 0, 1'b0, resp);
        check_eq("bme0_bresp", 256'(resp), 256'(2'b10));
        check_eq("bme0_no_tlp", 256'(q0.size() - n), 256'(0));
        check_eq("bme0_err_pulse", 256'(se0 - s_before), 256'(1));
        bme = 1'b1;
        do_write(0, 64'h0000_0002_0000_0040, 32'h5555_AAAA, 4'h3, 0, 0, 1'b1, resp);
        check_eq("bme1_bresp", 256'(resp), 256'(2'b00));
        exp_beat(0, "bme1", {96'h0, 32'h5555_AAAA, 32'h0, 32'h0000_0801, 32'h0000_0002, 32'h0000_0040},
                 8'h1F, 1'b1, 60'h3);

        // Bready held off ten cycles; zero strobes still emit a TLP.
        do_write(0, 64'h0000_0000_0000_0010, 32'h0000_0077, 4'h0, 0, 10, 1'b1, resp);
        check_eq("bhold_bresp", 256'(resp), 256'(2'b00));
        exp_beat(0, "bhold", {96'h0, 32'h0000_0077, 32'h0, 32'h0000_0801, 32'h0, 32'h0000_0010},
                 8'h1F, 1'b1, 60'h0);

        // Width 128 under random back-pressure.
        rand_en = 1'b1;
        b_count = 0;
        for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom};
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            n = q1.size();
            do_write(1, a, d, s, i % 3, 0, 1'b1, resp);
            if (resp == 2'b00) b_count++;
            check_eq("r128_nbeats", 256'(q1.size() - n), 256'(2));
            exp_beat(1, "r128_b0", {128'h0, 32'h0, 32'h0000_0801, a[63:32], a[31:2], 2'b00},
                     8'h0F, 1'b0, 60'(s));
            exp_beat(1, "r128_b1", 256'(d), 8'h01, 1'b1, 60'(s));
        end
        rand_en = 1'b0;
        check_eq("r128_bcount", 256'(b_count), 256'(200));

        // Width 64: reset during beat1 abandons the TLP.
        tready_set[2] = 1'b0;
        @(posedge clk);
        #1;
        awaddr = 64'h0000_0003_0000_0100;
        wdata  = 32'h1234_5678;
        wstrb  = 4'hF;
        awvalid[2] = 1'b1;
        wvalid[2]  = 1'b1;
        @(posedge clk);
        #1;
        awvalid[2] = 1'b0;
        wvalid[2]  = 1'b0;
        cyc = 0;
        while (!tvalid[2] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_t_beat0_valid", 256'(tvalid[2]), 256'(1'b1));
        tready_set[2] = 1'b1;
        @(posedge clk);
        #1;
        tready_set[2] = 1'b0;
        @(negedge clk);
        check_eq("rst_t_beat1_valid", 256'(tvalid[2]), 256'(1'b1));
        check_eq("rst_t_beat1_data", 256'(tdata_2), 256'(64'h0000_0000_0000_0801));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_t_valid", 256'({tvalid[2], tlast[2]}), 256'(0));
        check_eq("rst_t_stream", 256'({tdata_2, tkeep_2, tuser_2}), 256'(0));
        check_eq("rst_t_axil", 256'({awready[2], wready[2], bvalid[2], bresp_2, status_error[2]}), 256'(0));
        check_eq("rst_t_partial", 256'(q2.size()), 256'(1));
        q2.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tready_set[2] = 1'b1;
        do_write(2, 64'h0000_0000_0000_2000, 32'hA5A5_5A5A, 4'hC, 0, 0, 1'b1, resp);
        check_eq("rst_t_bresp", 256'(resp), 256'(2'b00));
        check_eq("rst_t_nbeats", 256'(q2.size()), 256'(3));
        exp_beat(2, "rst_t_b0", 256'(64'h0000_0000_0000_2000), 8'h03, 1'b0, 60'hC);
        exp_beat(2, "rst_t_b1", 256'(64'h0000_0000_0000_0801), 8'h03, 1'b0, 60'hC);
        exp_beat(2, "rst_t_b2", 256'(64'h0000_0000_A5A5_5A5A), 8'h01, 1'b1, 60'hC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
